fb_pattern_engine: RTL and testbench



---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_pattern_gen.sv | 59 +++++
 rtl/fb_pattern_engine.sv | 181 ++++++++++++++++++
 tb/tb_fb_pattern_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared encodings and address composition for the framebuffer pattern engine.
package fb_pkg;

   // Pattern selector, latched at start.
   typedef enum logic [1:0] {
      PAT_XRAMP   = 2'd0,
      PAT_YRAMP   = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_CONST   = 2'd3
   } pat_mode_t;

   // Operation selector, latched at start.
   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_CHECK = 1'b1
   } op_t;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Linear word address of pixel (x,y) at a power-of-two stride; callers
   // truncate the result to their address width.
   function automatic logic [63:0] compose_addr(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input int unsigned stride_log2);
      return ({32'd0, y} << stride_log2) | {32'd0, x};
   endfunction

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational pixel generator: (x, y, mode, const) -> pattern word.
module fb_pattern_gen
   import fb_pkg::*;
#(
   parameter int X_W      = 12,
   parameter int Y_W      = 10,
   parameter int DATA_W   = 16,
   parameter int CHK_LOG2 = 4
)(
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   input  pat_mode_t         mode,
   input  logic [DATA_W-1:0] const_val,
   output logic [DATA_W-1:0] pixel
);

   logic [DATA_W-1:0] x_word;
   logic [DATA_W-1:0] y_word;
   logic              chk_x;
   logic              chk_y;

   // Coordinates are zero-extended or truncated to the pixel width.
   if (X_W >= DATA_W) begin : g_x_trunc
      assign x_word = x[DATA_W-1:0];
   end else begin : g_x_ext
      assign x_word = {{(DATA_W-X_W){1'b0}}, x};
   end

   if (Y_W >= DATA_W) begin : g_y_trunc
      assign y_word = y[DATA_W-1:0];
   end else begin : g_y_ext
      assign y_word = {{(DATA_W-Y_W){1'b0}}, y};
   end

   // A square-size bit beyond the coordinate width is always zero.
   if (CHK_LOG2 < X_W) begin : g_chk_x
      assign chk_x = x[CHK_LOG2];
   end else begin : g_chk_x0
      assign chk_x = 1'b0;
   end

   if (CHK_LOG2 < Y_W) begin : g_chk_y
      assign chk_y = y[CHK_LOG2];
   end else begin : g_chk_y0
      assign chk_y = 1'b0;
   end

   // Select the pattern word for the current coordinate.
   always_comb begin
      // NOTE: pixel is assigned on every path (default arm) so no latch is inferred.
      case (mode)
         PAT_XRAMP:   pixel = x_word;
         PAT_YRAMP:   pixel = y_word;
         PAT_CHECKER: pixel = (chk_x ^ chk_y) ? '1 : '0;
         default:     pixel = const_val;
      endcase
   end

endmodule

// File: rtl/fb_pattern_engine.sv
// Framebuffer pattern writer / checker on the SDRAM request port.
// Write op fills the active frame; check op reads it back in order and
// counts mismatches against the regenerated pattern.
module fb_pattern_engine
   import fb_pkg::*;
#(
   parameter int H_ACTIVE        = 1280,
   parameter int V_ACTIVE        = 720,
   parameter int STRIDE_LOG2     = 12,
   parameter int ADDR_W          = 22,
   parameter int DATA_W          = 16,
   parameter int CHK_LOG2        = 4,
   parameter int MAX_OUTSTANDING = 8
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              op,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] const_val,
   output logic              busy,
   output logic              done,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_we,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              err_flag
);

   localparam int X_W   = STRIDE_LOG2;
   localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   state_t            state, state_next;
   op_t               op_q;
   pat_mode_t         mode_q;
   logic [DATA_W-1:0] const_q;

   logic [X_W-1:0]    x_q,  rx_q;
   logic [Y_W-1:0]    y_q,  ry_q;
   logic [OUT_W-1:0]  outstanding_q;

   logic [DATA_W-1:0] issue_pixel;
   logic [DATA_W-1:0] ret_pixel;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] ret_addr;

   logic start_ok;
   logic issue_stall;
   logic accept;
   logic last_accept;
   logic rd_accept;
   logic rd_fire;
   logic rd_mismatch;

   assign start_ok    = start && (state == ST_IDLE);
   assign issue_stall = (op_q == OP_CHECK) && (outstanding_q == OUT_MAX);
   assign accept      = req_valid && req_ready;
   assign last_accept = accept && (x_q == X_LAST) && (y_q == Y_LAST);
   assign rd_accept   = accept && (op_q == OP_CHECK);
   // Returns are only meaningful for a check op with reads in flight.
   assign rd_fire     = rd_valid && (op_q == OP_CHECK) && (outstanding_q != '0);
   assign rd_mismatch = rd_fire && (rd_data != ret_pixel);

   assign issue_addr = ADDR_W'(compose_addr(32'(x_q), 32'(y_q), STRIDE_LOG2));
   assign ret_addr   = ADDR_W'(compose_addr(32'(rx_q), 32'(ry_q), STRIDE_LOG2));

   fb_pattern_gen #(
      .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .CHK_LOG2(CHK_LOG2)
   ) u_issue_gen (
      .x(x_q), .y(y_q), .mode(mode_q), .const_val(const_q), .pixel(issue_pixel)
   );

   fb_pattern_gen #(
      .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .CHK_LOG2(CHK_LOG2)
   ) u_ret_gen (
      .x(rx_q), .y(ry_q), .mode(mode_q), .const_val(const_q), .pixel(ret_pixel)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start)                  state_next = ST_ISSUE;
         ST_ISSUE: if (last_accept)            state_next = ST_DRAIN;
         ST_DRAIN: if (outstanding_q == '0)    state_next = ST_DONE;
         default:                              state_next = ST_IDLE;
      endcase
   end

   // Outputs: payload is zero outside ISSUE and frozen by the counters while stalled.
   always_comb begin
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      req_valid = (state == ST_ISSUE) && !issue_stall;
      req_we    = (state == ST_ISSUE) && (op_q == OP_WRITE);
      req_addr  = (state == ST_ISSUE) ? issue_addr : '0;
      req_wdata = req_we ? issue_pixel : '0;
   end

   // Operation config latch plus issue and return scan counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q    <= OP_WRITE;
         mode_q  <= PAT_XRAMP;
         const_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
      end else if (start_ok) begin
         op_q    <= op_t'(op);
         mode_q  <= pat_mode_t'(mode);
         const_q <= const_val;
         x_q     <= '0;
         y_q     <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
      end else begin
         if (accept) begin
            if (x_q == X_LAST) begin
               x_q <= '0;
               y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
         if (rd_fire) begin
            if (rx_q == X_LAST) begin
               rx_q <= '0;
               ry_q <= (ry_q == Y_LAST) ? '0 : ry_q + 1'b1;
            end else begin
               rx_q <= rx_q + 1'b1;
            end
         end
      end
   end

   // Reads in flight: +1 on read accept, -1 on a counted return.
   always_ff @(posedge clk) begin
      if (!reset_n || start_ok) begin
         outstanding_q <= '0;
      end else begin
         case ({rd_accept, rd_fire})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   // Mismatch accounting; the first failing address is kept until the next start.
   always_ff @(posedge clk) begin
      if (!reset_n || start_ok) begin
         err_count      <= '0;
         err_flag       <= 1'b0;
         first_err_addr <= '0;
      end else if (rd_mismatch) begin
         if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         err_flag <= 1'b1;
         if (!err_flag) first_err_addr <= ret_addr;
      end
   end

endmodule

// File: tb/tb_fb_pattern_engine.sv
// Self-checking bench for fb_pattern_engine: a small frame instance driven by
// a request scoreboard and an in-order read memory, plus a large instance
// used for error-count saturation.
`timescale 1ns/1ps
module tb_fb_pattern_engine;

   localparam int H = 8, V = 4, SL = 4, AW = 8, DW = 16, CL = 1, MO = 2, LAT = 3;
   localparam int BH = 256, BV = 257, BSL = 8, BAW = 17, BMO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // Small instance
   logic          start, op, req_ready, rd_valid;
   logic [1:0]    mode;
   logic [DW-1:0] const_val, rd_data;
   logic          busy, done, req_valid, req_we, err_flag;
   logic [AW-1:0] req_addr, first_err_addr;
   logic [DW-1:0] req_wdata;
   logic [15:0]   err_count;

   // Large instance
   logic           b_start, b_op, b_req_ready, b_rd_valid;
   logic [1:0]     b_mode;
   logic [DW-1:0]  b_const, b_rd_data;
   logic           b_busy, b_done, b_req_valid, b_req_we, b_err_flag;
   logic [BAW-1:0] b_req_addr, b_first_err_addr;
   logic [DW-1:0]  b_req_wdata;
   logic [15:0]    b_err_count;

   fb_pattern_engine #(
      .H_ACTIVE(H), .V_ACTIVE(V), .STRIDE_LOG2(SL), .ADDR_W(AW),
      .DATA_W(DW), .CHK_LOG2(CL), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .mode(mode),
      .const_val(const_val), .busy(busy), .done(done), .req_valid(req_valid),
      .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
      .err_count(err_count), .first_err_addr(first_err_addr), .err_flag(err_flag)
   );

   fb_pattern_engine #(
      .H_ACTIVE(BH), .V_ACTIVE(BV), .STRIDE_LOG2(BSL), .ADDR_W(BAW),
      .DATA_W(DW), .CHK_LOG2(4), .MAX_OUTSTANDING(BMO)
   ) dut_big (
      .clk(clk), .reset_n(reset_n), .start(b_start), .op(b_op), .mode(b_mode),
      .const_val(b_const), .busy(b_busy), .done(b_done), .req_valid(b_req_valid),
      .req_ready(b_req_ready), .req_we(b_req_we), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
      .err_count(b_err_count), .first_err_addr(b_first_err_addr), .err_flag(b_err_flag)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } rd_t;

   req_t          exp_q[$];
   rd_t           pend_q[$];
   logic [DW-1:0] mem [0:255];
   bit            corrupt [0:255];

   int   checks = 0, passed = 0;
   int   cyc = 0, last_acc_cyc = 0, done_cyc = 0, done_cnt = 0;
   int   max_inflight = 0, exp_err = 0;
   bit   rand_ready = 0, poke_done_start = 0, err_pending = 0, stall_prev = 0;
   req_t stall_req;

   // Reference pattern model.
   function automatic logic [DW-1:0] pat(input int m, input int x, input int y, input logic [DW-1:0] c);
      case (m)
         0:       return DW'(x);
         1:       return DW'(y);
         2:       return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 16'hFFFF : 16'h0000;
         default: return c;
      endcase
   endfunction

   task automatic push_expected(input int m, input logic we, input logic [DW-1:0] c);
      req_t e;
      exp_q.delete();
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            e.we   = we;
            e.addr = AW'((y << SL) | x);
            e.data = we ? pat(m, x, y, c) : '0;
            exp_q.push_back(e);
         end
      end
   endtask

   // One cycle of bench activity, entered just after a falling edge.
   task automatic step();
      req_t got, e;
      rd_t  r;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (poke_done_start) begin start = 1'b1; op = 1'b1; end
      end
      if (err_pending) begin
         checks++;
         if (err_count !== 16'(exp_err))
            $display("FAIL err_visible: err_count=%0d expected %0d", err_count, exp_err);
         else passed++;
         err_pending = 0;
      end
      got = {req_we, req_addr, req_wdata};
      if (stall_prev) begin
         checks++;
         if (req_valid !== 1'b1 || got !== stall_req)
            $display("FAIL stall_hold: valid=%b payload=%h expected valid=1 payload=%h", req_valid, got, stall_req);
         else passed++;
      end
      rd_valid = 1'b0;
      rd_data  = '0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         r        = pend_q.pop_front();
         rd_valid = 1'b1;
         rd_data  = mem[r.addr];
         if (corrupt[r.addr]) begin exp_err++; err_pending = 1; end
      end
      req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req_valid && req_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL req_extra: unexpected request addr=%h we=%b", req_addr, req_we);
         end else begin
            e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL req_seq: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                        got.we, got.addr, got.data, e.we, e.addr, e.data);
            else passed++;
         end
         if (!req_we) begin
            r.due  = cyc + LAT;
            r.addr = req_addr;
            pend_q.push_back(r);
         end
         last_acc_cyc = cyc;
      end
      stall_prev = req_valid && !req_ready;
      stall_req  = got;
      if (pend_q.size() > max_inflight) max_inflight = pend_q.size();
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_done(input int budget, input string name);
      int n = 0;
      done_cnt = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      start = 1'b0;
      poke_done_start = 0;
      checks++;
      if (done_cnt == 0) $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      else passed++;
   endtask

   task automatic init_mem(input int a0, input int a1);
      for (int i = 0; i < 256; i++) begin mem[i] = 16'hDEAD; corrupt[i] = 0; end
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) mem[(y << SL) | x] = pat(1, x, y, '0);
      if (a0 >= 0) begin mem[a0] = ~mem[a0]; corrupt[a0] = 1; end
      if (a1 >= 0) begin mem[a1] = ~mem[a1]; corrupt[a1] = 1; end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, req_valid, req_we, req_addr, req_wdata, err_count, first_err_addr, err_flag} !== '0)
         $display("FAIL reset_small: busy=%b done=%b valid=%b we=%b addr=%h wdata=%h cnt=%h first=%h flag=%b expected all 0",
                  busy, done, req_valid, req_we, req_addr, req_wdata, err_count, first_err_addr, err_flag);
      else passed++;
      checks++;
      if ({b_busy, b_done, b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_err_count, b_first_err_addr, b_err_flag} !== '0)
         $display("FAIL reset_big: busy=%b valid=%b cnt=%h expected all 0", b_busy, b_req_valid, b_err_count);
      else passed++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_xramp();
      rand_ready = 0;
      push_expected(0, 1'b1, '0);
      op = 1'b0; mode = 2'd0; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({busy, req_valid} !== 2'b11)
         $display("FAIL start_latency: busy=%b req_valid=%b expected 1 1", busy, req_valid);
      else passed++;
      run_until_done(200, "wr_xramp");
      checks++;
      if (exp_q.size() != 0) $display("FAIL wr_xramp_count: %0d requests missing, expected 0", exp_q.size());
      else passed++;
      checks++;
      if (done_cyc - last_acc_cyc != 2)
         $display("FAIL done_latency: done %0d cycles after last accept, expected 2", done_cyc - last_acc_cyc);
      else passed++;
      checks++;
      if ({busy, done} !== 2'b00) $display("FAIL done_pulse: busy=%b done=%b expected 0 0", busy, done);
      else passed++;
   endtask

   task automatic test_write_checker();
      rand_ready = 1;
      stall_prev = 0;
      push_expected(2, 1'b1, '0);
      op = 1'b0; mode = 2'd2; start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      // start while busy must not disturb the running write
      start = 1'b1; op = 1'b1; mode = 2'd3; const_val = 16'h1234;
      step();
      start = 1'b0; op = 1'b0; mode = 2'd2;
      poke_done_start = 1;
      run_until_done(600, "wr_chk");
      checks++;
      if (exp_q.size() != 0) $display("FAIL wr_chk_count: %0d requests missing, expected 0", exp_q.size());
      else passed++;
      checks++;
      if ({busy, req_valid} !== 2'b00)
         $display("FAIL start_in_done: busy=%b req_valid=%b expected 0 0", busy, req_valid);
      else passed++;
      rand_ready = 0;
      stall_prev = 0;
   endtask

   task automatic test_check(input string name, input int a0, input int a1);
      int            exp_cnt;
      logic [AW-1:0] exp_first;
      init_mem(a0, a1);
      exp_cnt   = (a0 >= 0 ? 1 : 0) + (a1 >= 0 ? 1 : 0);
      exp_first = (a0 >= 0) ? AW'(a0) : '0;
      exp_err = 0; err_pending = 0; max_inflight = 0; stall_prev = 0;
      pend_q.delete();
      rand_ready = 0;
      push_expected(1, 1'b0, '0);
      op = 1'b1; mode = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      run_until_done(600, name);
      checks++;
      if (exp_q.size() != 0 || pend_q.size() != 0)
         $display("FAIL %s_reads: missing=%0d unreturned=%0d expected 0 0", name, exp_q.size(), pend_q.size());
      else passed++;
      checks++;
      if (max_inflight != MO) $display("FAIL %s_inflight: max=%0d expected %0d", name, max_inflight, MO);
      else passed++;
      checks++;
      if (err_count !== 16'(exp_cnt)) $display("FAIL %s_count: err_count=%0d expected %0d", name, err_count, exp_cnt);
      else passed++;
      checks++;
      if (err_flag !== (exp_cnt != 0)) $display("FAIL %s_flag: err_flag=%b expected %b", name, err_flag, exp_cnt != 0);
      else passed++;
      checks++;
      if (first_err_addr !== exp_first)
         $display("FAIL %s_first: first_err_addr=%h expected %h", name, first_err_addr, exp_first);
      else passed++;
   endtask

   task automatic test_reset_mid();
      init_mem(0, 1);
      exp_err = 0; err_pending = 0; stall_prev = 0;
      pend_q.delete();
      push_expected(1, 1'b0, '0);
      op = 1'b1; mode = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      checks++;
      if ({busy, err_flag} !== 2'b11) $display("FAIL mid_pre: busy=%b err_flag=%b expected 1 1", busy, err_flag);
      else passed++;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      pend_q.delete(); exp_q.delete();
      err_pending = 0; stall_prev = 0; rd_valid = 1'b0;
      checks++;
      if ({busy, done, req_valid, err_count, err_flag, first_err_addr} !== '0)
         $display("FAIL mid_reset: busy=%b done=%b valid=%b cnt=%0d flag=%b first=%h expected all 0",
                  busy, done, req_valid, err_count, err_flag, first_err_addr);
      else passed++;
      done_cnt = 0;
      repeat (30) step();
      checks++;
      if (done_cnt != 0 || busy !== 1'b0 || req_valid !== 1'b0)
         $display("FAIL mid_quiet: done pulses=%0d busy=%b valid=%b expected 0 0 0", done_cnt, busy, req_valid);
      else passed++;
   endtask

   task automatic test_saturate();
      int n = 0, acc = 0, ret = 0;
      bit acc_prev = 0, sat_next = 0;
      b_req_ready = 1'b1; b_op = 1'b1; b_mode = 2'd3; b_const = 16'hA5A5; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      while (b_done !== 1'b1 && n < 70000) begin
         if (sat_next) begin
            checks++;
            if (b_err_count !== 16'hFFFF) $display("FAIL sat_reach: err_count=%h expected ffff", b_err_count);
            else passed++;
            sat_next = 0;
         end
         b_rd_valid = acc_prev;
         b_rd_data  = 16'h5A5A;
         if (acc_prev) begin
            ret++;
            if (ret == 65535) sat_next = 1;
         end
         acc_prev = b_req_valid && b_req_ready;
         if (acc_prev) acc++;
         @(negedge clk);
         n++;
      end
      b_rd_valid = 1'b0;
      checks++;
      if (b_done !== 1'b1) $display("FAIL sat_timeout: no done within %0d cycles", n);
      else passed++;
      checks++;
      if (acc != BH * BV) $display("FAIL sat_reads: %0d reads issued, expected %0d", acc, BH * BV);
      else passed++;
      checks++;
      if ({b_err_count, b_err_flag} !== {16'hFFFF, 1'b1})
         $display("FAIL sat_final: err_count=%h flag=%b expected ffff 1", b_err_count, b_err_flag);
      else passed++;
      checks++;
      if (b_first_err_addr !== '0) $display("FAIL sat_first: first_err_addr=%h expected 0", b_first_err_addr);
      else passed++;
   endtask

   initial begin
      start = 1'b0; op = 1'b0; mode = 2'd0; const_val = '0;
      req_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
      b_start = 1'b0; b_op = 1'b0; b_mode = 2'd0; b_const = '0;
      b_req_ready = 1'b0; b_rd_valid = 1'b0; b_rd_data = '0;
      for (int i = 0; i < 256; i++) begin mem[i] = '0; corrupt[i] = 0; end
      reset_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_xramp();
      test_write_checker();
      test_check("chk_clean", -1, -1);
      test_check("chk_one", 'h23, -1);
      test_check("chk_two", 'h23, 'h31);
      test_reset_mid();
      test_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
